// File: rtl/j_dac_seq.sv
// Stereo DAC frame sequencer: counts 0..period on tick, swaps in a buffered
// sample pair at each frame wrap, and flags underrun when none is waiting.
module j_dac_seq (
  input  logic       clk,
  input  logic       resetl,
  input  logic       tick,
  input  logic       en,
  input  logic [7:0] period,
  input  logic       smp_valid,
  input  logic [6:0] smp_l,
  input  logic [6:0] smp_r,
  output logic       smp_ready,
  output logic [7:0] cnt,
  output logic [6:0] lvl_l,
  output logic [6:0] lvl_r,
  output logic       stop,
  output logic       frame,
  output logic       underrun,
  input  logic       underrun_clr
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOPPING} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, period_q, period_d;
  logic [6:0] lvl_l_q, lvl_l_d, lvl_r_q, lvl_r_d;
  logic [6:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic       hold_full_q, hold_full_d;
  logic       frame_q, frame_d, underrun_q, underrun_d;
  logic       accept, at_tc, wrap;

  assign accept = smp_valid & ~hold_full_q;
  assign at_tc  = (cnt_q == period_q);
  assign wrap   = tick & at_tc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    lvl_l_d     = lvl_l_q;
    lvl_r_d     = lvl_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q | accept;
    frame_d     = 1'b0;
    underrun_d  = underrun_clr ? 1'b0 : underrun_q;
    if (accept) begin
      hold_l_d = smp_l;
      hold_r_d = smp_r;
    end
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        lvl_l_d = '0;
        lvl_r_d = '0;
        if (en) state_d = ARM;
      end
      ARM: begin
        cnt_d = '0;
        if (!en) begin
          state_d = IDLE;
        end else if (hold_full_q) begin
          lvl_l_d     = hold_l_q;
          lvl_r_d     = hold_r_q;
          hold_full_d = 1'b0;
          period_d    = period;
          state_d     = RUN;
        end
      end
      RUN, STOPPING: begin
        state_d = en ? RUN : STOPPING;
        if (tick) begin
          if (!at_tc) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d    = '0;
            frame_d  = 1'b1;
            period_d = period;
            // A stop request still pending at the wrap ends the run here.
            if (state_q == STOPPING && !en) begin
              lvl_l_d = '0;
              lvl_r_d = '0;
              state_d = IDLE;
            end else if (hold_full_q) begin
              lvl_l_d     = hold_l_q;
              lvl_r_d     = hold_r_q;
              hold_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      lvl_l_q     <= '0;
      lvl_r_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      lvl_l_q     <= lvl_l_d;
      lvl_r_q     <= lvl_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign smp_ready = ~hold_full_q;
  assign cnt       = cnt_q;
  assign lvl_l     = lvl_l_q;
  assign lvl_r     = lvl_r_q;
  assign frame     = frame_q;
  assign underrun  = underrun_q;
  assign stop      = ((state_q == RUN) || (state_q == STOPPING)) && at_tc;

endmodule

// File: tb/tb_j_dac_seq.sv
// Directed bench for j_dac_seq: one task per scenario, hand-computed expectations.
module tb_j_dac_seq;

  logic       clk = 1'b0;
  logic       resetl, tick, en, smp_valid, underrun_clr;
  logic [7:0] period;
  logic [6:0] smp_l, smp_r;
  logic       smp_ready, stop, frame, underrun;
  logic [7:0] cnt;
  logic [6:0] lvl_l, lvl_r;
  int         n_cmp = 0;
  int         n_bad = 0;

  j_dac_seq dut (
    .clk(clk), .resetl(resetl), .tick(tick), .en(en), .period(period),
    .smp_valid(smp_valid), .smp_l(smp_l), .smp_r(smp_r), .smp_ready(smp_ready),
    .cnt(cnt), .lvl_l(lvl_l), .lvl_r(lvl_r), .stop(stop), .frame(frame),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetl = 1'b0; tick = 1'b0; en = 1'b0; smp_valid = 1'b0; underrun_clr = 1'b0;
    period = 8'd0; smp_l = '0; smp_r = '0;
    step(); step();
    resetl = 1'b1;
    step();
  endtask

  // Leaves the DUT in RUN with cnt=0 and the given levels loaded.
  task automatic start_run(input logic [7:0] p, input logic [6:0] l, input logic [6:0] r);
    period = p; en = 1'b1; tick = 1'b1; smp_valid = 1'b1; smp_l = l; smp_r = r;
    step();
    smp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tick = 1'b1;
    step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0 || lvl_r !== 7'd0) begin n_bad++; $display("FAIL reset_regs cnt=%0h l=%0h r=%0h want 0/0/0", cnt, lvl_l, lvl_r); end
    n_cmp++; if ({smp_ready, stop, frame, underrun} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags rdy/stop/frame/und=%b want 1000", {smp_ready, stop, frame, underrun}); end
  endtask

  task automatic test_start();
    logic [7:0] ec[5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    logic       es[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ef[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    start_run(8'd3, 7'h20, 7'h10);
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'h20 || lvl_r !== 7'h10 || smp_ready !== 1'b1) begin n_bad++; $display("FAIL start_load cnt=%0h l=%0h r=%0h rdy=%b want 0/20/10/1", cnt, lvl_l, lvl_r, smp_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (cnt !== ec[i] || stop !== es[i] || frame !== ef[i]) begin n_bad++; $display("FAIL start_seq[%0d] cnt=%0d stop=%b frame=%b want %0d/%b/%b", i, cnt, stop, frame, ec[i], es[i], ef[i]); end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    start_run(8'd2, 7'h05, 7'h06);
    step(); step(); step();
    n_cmp++; if (cnt !== 8'd0 || underrun !== 1'b1 || lvl_l !== 7'h05 || lvl_r !== 7'h06) begin n_bad++; $display("FAIL underrun_set cnt=%0d und=%b l=%0h r=%0h want 0/1/05/06", cnt, underrun, lvl_l, lvl_r); end
    tick = 1'b0; underrun_clr = 1'b1;
    step();
    n_cmp++; if (underrun !== 1'b0 || cnt !== 8'd0) begin n_bad++; $display("FAIL underrun_clr und=%b cnt=%0d want 0/0", underrun, cnt); end
    tick = 1'b1;
    step(); step();
    n_cmp++; if (underrun !== 1'b0 || cnt !== 8'd2) begin n_bad++; $display("FAIL underrun_held_clr und=%b cnt=%0d want 0/2", underrun, cnt); end
    step();
    n_cmp++; if (underrun !== 1'b1 || cnt !== 8'd0) begin n_bad++; $display("FAIL underrun_set_wins und=%b cnt=%0d want 1/0", underrun, cnt); end
    underrun_clr = 1'b0;
  endtask

  task automatic test_period_change();
    logic [7:0] ec[6] = '{8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd0};
    logic       es[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    start_run(8'd5, 7'h01, 7'h02);
    step(); step();
    period = 8'd1;
    n_cmp++; if (cnt !== 8'd2 || stop !== 1'b0) begin n_bad++; $display("FAIL pchg_pre cnt=%0d stop=%b want 2/0", cnt, stop); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (cnt !== ec[i] || stop !== es[i]) begin n_bad++; $display("FAIL pchg_seq[%0d] cnt=%0d stop=%b want %0d/%b", i, cnt, stop, ec[i], es[i]); end
    end
  endtask

  task automatic test_graceful_stop();
    do_reset();
    start_run(8'd4, 7'h11, 7'h12);
    smp_valid = 1'b1; smp_l = 7'h33; smp_r = 7'h34;
    step();
    smp_valid = 1'b0; en = 1'b0;
    step(); step();
    n_cmp++; if (cnt !== 8'd3 || lvl_l !== 7'h11) begin n_bad++; $display("FAIL stop_counting cnt=%0d l=%0h want 3/11", cnt, lvl_l); end
    step();
    n_cmp++; if (cnt !== 8'd4 || stop !== 1'b1) begin n_bad++; $display("FAIL stop_tc cnt=%0d stop=%b want 4/1", cnt, stop); end
    step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0 || lvl_r !== 7'd0 || frame !== 1'b1 || underrun !== 1'b0 || smp_ready !== 1'b0) begin n_bad++; $display("FAIL stop_idle cnt=%0d l=%0h r=%0h fr=%b und=%b rdy=%b want 0/0/0/1/0/0", cnt, lvl_l, lvl_r, frame, underrun, smp_ready); end
    step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0) begin n_bad++; $display("FAIL stop_stays_idle cnt=%0d l=%0h want 0/0", cnt, lvl_l); end
    en = 1'b1;
    step(); step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'h33 || lvl_r !== 7'h34 || smp_ready !== 1'b1) begin n_bad++; $display("FAIL rerun_load cnt=%0d l=%0h r=%0h rdy=%b want 0/33/34/1", cnt, lvl_l, lvl_r, smp_ready); end
    step();
    en = 1'b0;
    step(); step();
    en = 1'b1;
    n_cmp++; if (cnt !== 8'd3) begin n_bad++; $display("FAIL rerun_cnt3 cnt=%0d want 3", cnt); end
    step(); step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'h33 || underrun !== 1'b1) begin n_bad++; $display("FAIL reenable_wrap cnt=%0d l=%0h und=%b want 0/33/1", cnt, lvl_l, underrun); end
    step();
    n_cmp++; if (cnt !== 8'd1 || lvl_l !== 7'h33) begin n_bad++; $display("FAIL reenable_run cnt=%0d l=%0h want 1/33", cnt, lvl_l); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_run(8'd2, 7'h11, 7'h01);
    smp_valid = 1'b1; smp_l = 7'h22; smp_r = 7'h02;
    step();
    smp_l = 7'h44; smp_r = 7'h04;
    n_cmp++; if (smp_ready !== 1'b0 || cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_first rdy=%b cnt=%0d want 0/1", smp_ready, cnt); end
    step();
    n_cmp++; if (smp_ready !== 1'b0 || lvl_l !== 7'h11) begin n_bad++; $display("FAIL b2b_blocked rdy=%b l=%0h want 0/11", smp_ready, lvl_l); end
    step();
    n_cmp++; if (smp_ready !== 1'b1 || cnt !== 8'd0 || lvl_l !== 7'h22 || lvl_r !== 7'h02) begin n_bad++; $display("FAIL b2b_wrap rdy=%b cnt=%0d l=%0h r=%0h want 1/0/22/02", smp_ready, cnt, lvl_l, lvl_r); end
    step();
    smp_valid = 1'b0;
    n_cmp++; if (smp_ready !== 1'b0 || cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_second rdy=%b cnt=%0d want 0/1", smp_ready, cnt); end
    step(); step();
    n_cmp++; if (lvl_l !== 7'h44 || lvl_r !== 7'h04 || underrun !== 1'b0 || smp_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_load2 l=%0h r=%0h und=%b rdy=%b want 44/04/0/1", lvl_l, lvl_r, underrun, smp_ready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run(8'd4, 7'h2a, 7'h15);
    step();
    smp_valid = 1'b1; smp_l = 7'h7f; smp_r = 7'h7e;
    step();
    smp_valid = 1'b0;
    n_cmp++; if (cnt !== 8'd2 || smp_ready !== 1'b0) begin n_bad++; $display("FAIL arst_pre cnt=%0d rdy=%b want 2/0", cnt, smp_ready); end
    #2 resetl = 1'b0;
    #1;
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0 || lvl_r !== 7'd0 || {smp_ready, stop, frame, underrun} !== 4'b1000) begin n_bad++; $display("FAIL arst_now cnt=%0d l=%0h r=%0h flags=%b want 0/0/0/1000", cnt, lvl_l, lvl_r, {smp_ready, stop, frame, underrun}); end
    #1 resetl = 1'b1; en = 1'b0;
    step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0 || smp_ready !== 1'b1) begin n_bad++; $display("FAIL arst_idle cnt=%0d l=%0h rdy=%b want 0/0/1", cnt, lvl_l, smp_ready); end
    en = 1'b1;
    step(); step();
    n_cmp++; if (cnt !== 8'd0 || lvl_l !== 7'd0) begin n_bad++; $display("FAIL arst_sample_dropped cnt=%0d l=%0h want 0/0", cnt, lvl_l); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_underrun();
    test_period_change();
    test_graceful_stop();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
